// File: rtl/sdram_pkg.sv
// Shared types and Avalon widths for the SDRAM arbiter slice.
// Port-id width is derived per instance from NUM_PORTS via id_w().
package sdram_pkg;

   localparam int AVS_AW   = 24;
   localparam int AVS_DW   = 32;
   localparam int AVS_BYTE = AVS_DW / 8;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdram_id_fifo.sv
// In-order FIFO of port ids for outstanding reads.
// A push is accepted on a full FIFO only when a pop happens in the same cycle.
module sdram_id_fifo
   import sdram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_id,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PW = id_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM access port among NUM_PORTS masters.
// Read responses are routed back in order through an id FIFO.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int NUM_PORTS     = 2,
   parameter int ID_FIFO_DEPTH = 4,
   parameter int RESP_BEATS    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          m_req_valid,
   input  logic [NUM_PORTS-1:0]          m_req_write,
   input  logic [NUM_PORTS*AVS_AW-1:0]   m_req_address,
   input  logic [NUM_PORTS*AVS_DW-1:0]   m_req_writedata,
   input  logic [NUM_PORTS*AVS_BYTE-1:0] m_req_byteenable,
   output logic [NUM_PORTS-1:0]          m_req_ready,
   output logic [NUM_PORTS-1:0]          m_resp_valid,
   output logic [AVS_DW-1:0]             m_resp_readdata,
   output logic                          bus_req_valid,
   output logic                          bus_req_write,
   output logic [AVS_AW-1:0]             bus_req_address,
   output logic [AVS_DW-1:0]             bus_req_writedata,
   output logic [AVS_BYTE-1:0]           bus_req_byteenable,
   input  logic                          bus_req_ready,
   input  logic                          bus_resp_valid,
   input  logic [AVS_DW-1:0]             bus_resp_readdata,
   output logic                          resp_orphan_err
);

   localparam int IDW = id_w(NUM_PORTS);
   localparam int BCW = id_w(RESP_BEATS + 1);

   typedef logic [IDW-1:0] port_id_t;

   arb_state_t           state_q;
   arb_state_t           state_d;
   port_id_t             rr_ptr_q;
   port_id_t             rr_ptr_d;
   port_id_t             grant_q;
   port_id_t             grant_d;
   port_id_t             win;
   port_id_t             sel;
   port_id_t             head;
   logic                 found;
   logic                 req_v;
   logic                 fire;
   logic                 push;
   logic                 pop;
   logic                 resp_hit;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [NUM_PORTS-1:0] elig;
   logic [BCW-1:0]       beat_q;
   logic                 orphan_q;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++)
         elig[p] = m_req_valid[p] && (m_req_write[p] || !fifo_full);
   end

   // First eligible port at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = port_id_t'(idx);
         end
      end
   end

   always_comb begin
      sel   = win;
      req_v = found;
      if (state_q == ARB_LOCK) begin
         sel   = grant_q;
         req_v = m_req_valid[grant_q];
      end
      if (reset) req_v = 1'b0;
   end

   assign fire = req_v && bus_req_ready;
   assign push = fire && !m_req_write[sel];

   always_comb begin
      bus_req_valid      = req_v;
      bus_req_write      = m_req_write[sel];
      bus_req_address    = m_req_address[int'(sel)*AVS_AW +: AVS_AW];
      bus_req_writedata  = m_req_writedata[int'(sel)*AVS_DW +: AVS_DW];
      bus_req_byteenable = m_req_byteenable[int'(sel)*AVS_BYTE +: AVS_BYTE];
      m_req_ready        = '0;
      if (fire) m_req_ready[sel] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (found && !bus_req_ready) begin
               state_d = ARB_LOCK;
               grant_d = win;
            end
         end
         ARB_LOCK: begin
            if (fire) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
      if (fire)
         rr_ptr_d = (sel == port_id_t'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign resp_hit        = bus_resp_valid && !fifo_empty && !reset;
   assign pop             = resp_hit && (beat_q == BCW'(RESP_BEATS - 1));
   assign m_resp_readdata = bus_resp_readdata;
   assign resp_orphan_err = orphan_q;

   always_comb begin
      m_resp_valid = '0;
      if (resp_hit) m_resp_valid[head] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q   <= '0;
         orphan_q <= 1'b0;
      end else begin
         if (resp_hit) beat_q <= pop ? '0 : beat_q + 1'b1;
         if (bus_resp_valid && fifo_empty) orphan_q <= 1'b1;
      end
   end

   sdram_id_fifo #(
      .DEPTH (ID_FIFO_DEPTH),
      .W     (IDW)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .push_id (sel),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (head)
   );

endmodule
